if_fetch_stage: RTL and testbench

- Instruction-fetch stage directly upstream of the main decoder/control unit in the single-issue MIPS pipeline.
- Owns the PC and issues requests to instruction memory over a req/ack handshake that tolerates variable latency.
- Holds the fetched instruction in an IF/ID output register and supplies `opcode` (instr[31:26]) to the decoder.
- Accepts jump/taken-branch redirects from downstream, and handles stalls with a one-entry skid buffer.

---
 rtl/if_fetch_stage.sv | 205 ++++++++++++++++++++
 tb/tb_if_fetch_stage.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction-fetch stage of the single-issue MIPS pipeline. Owns the PC,
// fetches from instruction memory over a variable-latency req/ack handshake,
// and holds the fetched word in the IF/ID register feeding the decoder.
// Downstream stalls are absorbed by a one-entry skid buffer; jump and
// taken-branch redirects flush the IF/ID register and restart fetch.
//
// Parameters:
//   ADDR_W    PC/address width (verified at 32)
//   RESET_PC  first address fetched after reset
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   imem_req/imem_addr        fetch request, address held until imem_ack
//   imem_ack/imem_rdata       response strobe and instruction word
//   stall                     downstream cannot take if_instr this cycle
//   jump/jump_target          jump redirect
//   branch_taken/branch_target  resolved taken-branch redirect
//   if_valid/if_instr/if_pc4  IF/ID register contents
//   opcode                    if_instr[31:26] when valid, else 0
//   misalign_err              (IF_MISALIGN_CHECK_EN only) sticky flag, set by
//                             any redirect to a non-word-aligned target
//
// Build option: define IF_MISALIGN_CHECK_EN to add misalign_err.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | first cycle after reset, no request outstanding
// WAIT  | request outstanding at req_addr, data used on ack
// HOLD  | IF/ID full and stalled, next word parked in skid, no request
// DROP  | redirect arrived mid-request; finish handshake, discard data
// ---------------------------------------------------------------------------
module if_fetch_stage #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
`ifdef IF_MISALIGN_CHECK_EN
  output logic              misalign_err,
`endif
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc4,
  output logic [5:0]        opcode
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD, DROP} state_t;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic [ADDR_W-1:0] req_addr, req_addr_n;
  logic [31:0]       skid, skid_n;
  logic [ADDR_W-1:0] skid_pc4, skid_pc4_n;
  logic              if_valid_n;
  logic [31:0]       if_instr_n;
  logic [ADDR_W-1:0] if_pc4_n;

  logic              redirect;
  logic [ADDR_W-1:0] target_raw;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc_plus4;
  logic              consume;

  assign redirect   = jump | branch_taken;
  assign target_raw = jump ? jump_target : branch_target;
  assign target     = target_raw & ALIGN_MASK;
  assign pc_plus4   = pc + PC_STEP;
  assign consume    = if_valid & ~stall;

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      skid     <= '0;
      skid_pc4 <= '0;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc4   <= '0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      req_addr <= req_addr_n;
      skid     <= skid_n;
      skid_pc4 <= skid_pc4_n;
      if_valid <= if_valid_n;
      if_instr <= if_instr_n;
      if_pc4   <= if_pc4_n;
    end
  end

  // next-state and datapath update
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    req_addr_n = req_addr;
    skid_n     = skid;
    skid_pc4_n = skid_pc4;
    if_valid_n = if_valid;
    if_instr_n = if_instr;
    if_pc4_n   = if_pc4;

    if (redirect) begin
      pc_n       = target;
      if_valid_n = 1'b0;
      unique case (state)
        IDLE: begin
          state_n    = WAIT;
          req_addr_n = target;
        end
        WAIT: begin
          if (imem_ack) begin
            req_addr_n = target;
          end else begin
            // request must stay stable until acked, so park in DROP
            state_n = DROP;
          end
        end
        HOLD: begin
          state_n    = WAIT;
          req_addr_n = target;
        end
        DROP: begin
          state_n = DROP;
        end
        default: state_n = IDLE;
      endcase
    end else begin
      unique case (state)
        IDLE: begin
          state_n    = WAIT;
          req_addr_n = pc;
        end
        WAIT: begin
          if (imem_ack) begin
            if (!if_valid || !stall) begin
              if_instr_n = imem_rdata;
              if_pc4_n   = pc_plus4;
              if_valid_n = 1'b1;
              pc_n       = pc_plus4;
              req_addr_n = pc_plus4;
            end else begin
              skid_n     = imem_rdata;
              skid_pc4_n = pc_plus4;
              pc_n       = pc_plus4;
              state_n    = HOLD;
            end
          end else if (consume) begin
            if_valid_n = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            if_instr_n = skid;
            if_pc4_n   = skid_pc4;
            if_valid_n = 1'b1;
            req_addr_n = pc;
            state_n    = WAIT;
          end
        end
        DROP: begin
          if (imem_ack) begin
            req_addr_n = pc;
            state_n    = WAIT;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // outputs
  always_comb begin
    imem_req  = (state == WAIT) || (state == DROP);
    imem_addr = req_addr;
    opcode    = if_valid ? if_instr[31:26] : 6'b000000;
  end

`ifdef IF_MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_err <= 1'b0;
    end else if (redirect && (target_raw[1:0] != 2'b00)) begin
      misalign_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage
//
// Directed scenarios with fixed expected values, then a randomized phase
// checked against a transaction-level model: every instruction the stage
// presents must be the memory word of the next address on the program path
// (sequential, restarting at the aligned target after each redirect).
// ---------------------------------------------------------------------------
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        jump;
  logic [31:0] jump_target;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;
  logic [5:0]  opcode;
`ifdef IF_MISALIGN_CHECK_EN
  logic        misalign_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // memory model controls
  bit hash_en  = 1'b0;
  bit mem_rand = 1'b0;
  int mem_lat  = 0;
  int wait_cnt = 0;

  if_fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
`ifdef IF_MISALIGN_CHECK_EN
    .misalign_err  (misalign_err),
`endif
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc4        (if_pc4),
    .opcode        (opcode)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return hash_en ? ((a * 32'h9E37_79B1) ^ 32'hA5C3_0F1E) : a;
  endfunction

  task automatic drive_mem();
    if (imem_req === 1'b1) begin
      if (mem_rand) imem_ack = ($urandom_range(0, 2) != 0);
      else          imem_ack = (wait_cnt >= mem_lat);
      imem_rdata = imem_ack ? memfn(imem_addr) : $urandom;
      if (imem_ack) wait_cnt = 0;
      else          wait_cnt++;
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      wait_cnt   = 0;
    end
  endtask

  // one cycle: at the falling edge apply this cycle's inputs
  task automatic step(input bit r, input bit s, input bit j, input logic [31:0] jt,
                      input bit b, input logic [31:0] bt);
    @(negedge clk);
    rst           = r;
    stall         = s;
    jump          = j;
    jump_target   = jt;
    branch_taken  = b;
    branch_target = bt;
    drive_mem();
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF0 | {28'h0, 4'($urandom)};
    else                           t = {16'h0, 16'($urandom)};
    return t;
  endfunction

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] w;
    logic [31:0] hs_addr;
    logic [31:0] jt, bt;
    bit          hs_pend;
    bit          s, j, b;
    int          r;
    int          delivered;

    rst = 1'b1; stall = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    jump_target = '0; branch_target = '0; imem_ack = 1'b0; imem_rdata = '0;

    // ---- reset and back-to-back fetch, memory acks immediately, rdata=addr
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    idle_step();                                   // c0
    check("rst_req",    imem_req, 0);
    check("rst_valid",  if_valid, 0);
    check("rst_instr",  if_instr, 0);
    check("rst_pc4",    if_pc4,   0);
    check("rst_opcode", opcode,   0);
`ifdef IF_MISALIGN_CHECK_EN
    check("rst_misalign", misalign_err, 0);
`endif
    idle_step();                                   // c1
    check("first_req",  imem_req,  1);
    check("addr0",      imem_addr, 32'h0);
    idle_step();                                   // c2
    check("addr4",      imem_addr, 32'h4);
    check("instr0",     if_instr,  32'h0);
    check("valid0",     if_valid,  1);
    check("pc4_0",      if_pc4,    32'h4);
    idle_step();                                   // c3
    check("addr8",      imem_addr, 32'h8);
    check("instr4",     if_instr,  32'h4);

    // ---- stall for three cycles with ack arriving
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);   // c4
    check("instr8",     if_instr,  32'h8);
    check("addr12",     imem_addr, 32'hC);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);   // c5
    check("hold_req",   imem_req,  0);
    check("hold_instr", if_instr,  32'h8);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);   // c6
    check("hold_req2",  imem_req,  0);
    idle_step();                                   // c7
    check("hold_instr3", if_instr, 32'h8);
    idle_step();                                   // c8
    check("skid_instr", if_instr,  32'hC);
    check("skid_pc4",   if_pc4,    32'h10);
    check("post_addr",  imem_addr, 32'h10);
    idle_step();                                   // c9
    check("post_instr", if_instr,  32'h10);

    // ---- jump while the request is pending (ack delayed 3 cycles)
    mem_lat = 3;
    step(1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 32'h0);  // c10
    check("pre_jump_addr", imem_addr, 32'h18);
    idle_step();                                   // c11
    check("drop_addr1", imem_addr, 32'h18);
    check("drop_req1",  imem_req,  1);
    check("drop_valid", if_valid,  0);
    check("drop_opcode", opcode,   0);
    idle_step();                                   // c12
    check("drop_addr2", imem_addr, 32'h18);
    idle_step();                                   // c13
    check("drop_addr3", imem_addr, 32'h18);
    check("drop_ack",   imem_ack,  1);
    mem_lat = 0;
    idle_step();                                   // c14
    check("jump_addr",  imem_addr, 32'h100);
    check("jump_valid", if_valid,  0);

    // ---- jump and branch together: jump wins
    step(1'b0, 1'b0, 1'b1, 32'h0000_0040, 1'b1, 32'h0000_0080);  // c15
    check("jump_instr", if_instr,  32'h100);
    check("jump_pc4",   if_pc4,    32'h104);
    idle_step();                                   // c16
    check("prio_addr",  imem_addr, 32'h40);
    check("prio_valid", if_valid,  0);

    // ---- wrap from the top of the address space
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);  // c17
    check("prio_instr", if_instr,  32'h40);
    idle_step();                                   // c18
    check("top_addr",   imem_addr, 32'hFFFF_FFFC);
    idle_step();                                   // c19
    check("wrap_addr",  imem_addr, 32'h0);
    check("wrap_pc4",   if_pc4,    32'h0);
    check("wrap_instr", if_instr,  32'hFFFF_FFFC);

    // ---- misaligned branch target is aligned
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0102);  // c20
    idle_step();                                   // c21
    check("align_addr", imem_addr, 32'h100);
`ifdef IF_MISALIGN_CHECK_EN
    check("misalign_set", misalign_err, 1);
`endif

    // ---- randomized phase against the program-path model
    hash_en  = 1'b1;
    mem_rand = 1'b1;
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    exp_pc    = 32'h0;
    hs_pend   = 1'b0;
    hs_addr   = '0;
    delivered = 0;
    for (int k = 0; k < 3000; k++) begin
      s  = ($urandom_range(0, 9) < 3);
      r  = $urandom_range(0, 99);
      j  = (r < 4);
      b  = (r >= 2) && (r < 7);
      jt = rand_target();
      bt = rand_target();
      step(1'b0, s, j, jt, b, bt);
      if (hs_pend) begin
        check("hs_req",  imem_req,  1);
        check("hs_addr", imem_addr, hs_addr);
      end
      hs_pend = imem_req && !imem_ack;
      hs_addr = imem_addr;
      if (if_valid) begin
        w = memfn(exp_pc);
        check("rnd_instr",  if_instr, w);
        check("rnd_pc4",    if_pc4,   exp_pc + 32'd4);
        check("rnd_opcode", opcode,   {26'h0, w[31:26]});
        if (!s) begin
          exp_pc = exp_pc + 32'd4;
          delivered++;
        end
      end else begin
        check("rnd_opcode0", opcode, 0);
      end
      if (j || b) exp_pc = (j ? jt : bt) & 32'hFFFF_FFFC;
    end
    check("progress", (delivered >= 300) ? 32'd1 : 32'd0, 1);
`ifdef IF_MISALIGN_CHECK_EN
    check("misalign_sticky", misalign_err, 1);
`endif

    // ---- reset in mid-stream forgets the outstanding request
    mem_rand = 1'b0;
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    idle_step();
    check("rst2_req",   imem_req, 0);
    check("rst2_valid", if_valid, 0);
    check("rst2_instr", if_instr, 0);
`ifdef IF_MISALIGN_CHECK_EN
    check("rst2_misalign", misalign_err, 0);
`endif
    idle_step();
    check("rst2_addr",  imem_addr, 32'h0);
    check("rst2_req1",  imem_req,  1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
